// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one simple-dual-port BRAM between clients A and B.
// Optional macro BRAM_PORT_ARBITER_FWD_EN: a read accepted on the same edge as a write to the
// same address returns the new write data instead of the RAM's old data.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  a_wr_req,
  input  logic [ADDR_WIDTH-1:0] a_wr_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic                  a_wr_gnt,
  input  logic                  b_wr_req,
  input  logic [ADDR_WIDTH-1:0] b_wr_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic                  b_wr_gnt,
  input  logic                  a_rd_req,
  input  logic [ADDR_WIDTH-1:0] a_rd_addr,
  output logic                  a_rd_gnt,
  input  logic                  b_rd_req,
  input  logic [ADDR_WIDTH-1:0] b_rd_addr,
  output logic                  b_rd_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] data_addra,
  output logic [DATA_WIDTH-1:0] data_dina,
  output logic                  data_wea,
  output logic [ADDR_WIDTH-1:0] data_addrb,
  output logic                  data_enb,
  output logic                  regceb,
  output logic                  rstb,
  input  logic [DATA_WIDTH-1:0] data_doutb
);
  localparam int L = READ_LATENCY;
  logic                  wr_last_b_q, wr_last_b_d, rd_last_b_q, rd_last_b_d;
  logic                  wr_acc, rd_acc;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_src;
  logic                  wea_q, wea_d, enb_q, enb_d, rstb_q;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d;
  logic [DATA_WIDTH-1:0] dina_q, dina_d;
  logic [L:0]            tvld_q, tvld_d, tid_q, tid_d;

  // A wins a contention unless it was the last one granted on that port
  assign a_wr_gnt = a_wr_req & (~b_wr_req | wr_last_b_q);
  assign b_wr_gnt = b_wr_req & ~a_wr_gnt;
  assign a_rd_gnt = a_rd_req & (~b_rd_req | rd_last_b_q);
  assign b_rd_gnt = b_rd_req & ~a_rd_gnt;
  assign wr_acc   = a_wr_gnt | b_wr_gnt;
  assign rd_acc   = a_rd_gnt | b_rd_gnt;
  assign wr_addr  = a_wr_gnt ? a_wr_addr : b_wr_addr;
  assign wr_data  = a_wr_gnt ? a_wr_data : b_wr_data;
  assign rd_addr  = a_rd_gnt ? a_rd_addr : b_rd_addr;

  // Next state: pointers track the last winner, command regs capture accepts, tags shift
  always_comb begin
    wr_last_b_d = wr_acc ? b_wr_gnt : wr_last_b_q;
    rd_last_b_d = rd_acc ? b_rd_gnt : rd_last_b_q;
    wea_d       = wr_acc;
    addra_d     = wr_acc ? wr_addr : addra_q;
    dina_d      = wr_acc ? wr_data : dina_q;
    enb_d       = rd_acc;
    addrb_d     = rd_acc ? rd_addr : addrb_q;
    tvld_d      = {tvld_q[L-1:0], rd_acc};
    tid_d       = {tid_q[L-1:0], b_rd_gnt};
  end

  // State registers; rstb stays high until the first edge after reset release
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      wr_last_b_q <= 1'b1;
      rd_last_b_q <= 1'b1;
      rstb_q      <= 1'b1;
      wea_q       <= 1'b0;
      enb_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      addrb_q     <= '0;
      tvld_q      <= '0;
      tid_q       <= '0;
    end else begin
      wr_last_b_q <= wr_last_b_d;
      rd_last_b_q <= rd_last_b_d;
      rstb_q      <= 1'b0;
      wea_q       <= wea_d;
      enb_q       <= enb_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      addrb_q     <= addrb_d;
      tvld_q      <= tvld_d;
      tid_q       <= tid_d;
    end
  end

`ifdef BRAM_PORT_ARBITER_FWD_EN
  logic [L:0]                 tfwd_q, tfwd_d;
  logic [L:0][DATA_WIDTH-1:0] tdat_q, tdat_d;

  // Each tag also carries whether a same-edge write hit its address, and that write's data
  always_comb begin
    tfwd_d = {tfwd_q[L-1:0], wr_acc & rd_acc & (wr_addr == rd_addr)};
    tdat_d = {tdat_q[L-1:0], wr_data};
  end

  // Forwarding tag registers
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      tfwd_q <= '0;
      tdat_q <= '0;
    end else begin
      tfwd_q <= tfwd_d;
      tdat_q <= tdat_d;
    end
  end

  assign rd_src = tfwd_q[L] ? tdat_q[L] : data_doutb;
`else
  assign rd_src = data_doutb;
`endif

  assign data_wea   = wea_q;
  assign data_addra = addra_q;
  assign data_dina  = dina_q;
  assign data_enb   = enb_q;
  assign data_addrb = addrb_q;
  assign regceb     = 1'b1;
  assign rstb       = rstb_q;
  assign a_rvalid   = tvld_q[L] & ~tid_q[L];
  assign b_rvalid   = tvld_q[L] & tid_q[L];
  assign a_rdata    = a_rvalid ? rd_src : '0;
  assign b_rdata    = b_rvalid ? rd_src : '0;
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one simple-dual-port block RAM (one write port, one read port, common clock) between two clients, A and B.
- Write and read ports are arbitrated independently, each round-robin.
- Drives the RAM command signals from registers and routes read data back to the client that issued the read, with a valid strobe.

Parameters:
ADDR_WIDTH, 10, RAM address width (RAM depth 1024)
DATA_WIDTH, 18, RAM data width
READ_LATENCY, 2, RAM read latency in clocks; 2 = output register (HIGH_PERFORMANCE), 1 = LOW_LATENCY; other values illegal

Ports:
clka  in  1  single clock, feeds RAM clka and clkb
rst_n  in  1  asynchronous active-low reset
a_wr_req / b_wr_req  in  1  write request; held with addr/data until granted
a_wr_addr / b_wr_addr  in  ADDR_WIDTH  write address
a_wr_data / b_wr_data  in  DATA_WIDTH  write data
a_wr_gnt / b_wr_gnt  out  1  write accepted this cycle (combinational)
a_rd_req / b_rd_req  in  1  read request; held with addr until granted
a_rd_addr / b_rd_addr  in  ADDR_WIDTH  read address
a_rd_gnt / b_rd_gnt  out  1  read accepted this cycle (combinational)
a_rvalid / b_rvalid  out  1  read data valid, one-cycle pulse
a_rdata / b_rdata  out  DATA_WIDTH  read data, meaningful only while rvalid
data_addra  out  ADDR_WIDTH  RAM write address (registered)
data_dina  out  DATA_WIDTH  RAM write data (registered)
data_wea  out  1  RAM write enable (registered)
data_addrb  out  ADDR_WIDTH  RAM read address (registered)
data_enb  out  1  RAM read enable (registered)
regceb  out  1  RAM output register enable; constant 1
rstb  out  1  RAM output register reset
data_doutb  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registered outputs are 0, except rstb = 1.
  - Read tag pipeline cleared; in-flight reads dropped, no rvalid issued for them.
  - Both round-robin pointers set to "B last" (A wins the first contention).
  - rstb deasserts on the first clka edge after rst_n rises.
- Grants: gnt = req AND selected. Each port grants at most one client per cycle.
  - Only one requester: that requester is granted.
  - Both requesting: the client not granted most recently on that port wins; the port's pointer updates on every grant.
  - A write and a read may be granted in the same cycle, to the same or different clients.
- Accept: an accept is req and gnt both high at a clka edge.
  - A write accepted at edge N drives data_wea/data_addra/data_dina high/valid for the cycle after edge N. The RAM writes at edge N+1.
  - data_wea is 0 in any cycle with no accept.
- Read pipeline:
  - A read accepted at edge N drives data_enb=1 and data_addrb in the cycle after N.
  - The client id is shifted through a READ_LATENCY+1 deep tag pipe.
  - The owner's rvalid is high for exactly the cycle after edge N+READ_LATENCY.
  - rdata = data_doutb in that cycle. The other client's rvalid stays 0.
  - Back-to-back reads give one result per cycle, in accept order.
- Hazard: write and read to the same address accepted at the same edge returns the OLD data (RAM reads first). A read accepted one or more cycles after the write returns the new data.
- a_rdata/b_rdata are 0 whenever the corresponding rvalid is 0.
- Reset asserted mid-operation: pending reads never complete. Clients must reissue them.

Optional Feature:
- Macro: BRAM_PORT_ARBITER_FWD_EN.
- Defined: on a same-edge write/read accept to the same address, the write data is captured and carried alongside the tag. The returned rdata is the new write data instead of data_doutb. rvalid timing is unchanged.
- Undefined: old-data behaviour as above; no compare/forward logic is synthesized.

Test Plan:
- Reset then A writes 0x155 to addr 0x010; 3 cycles later A reads 0x010 -> a_rvalid exactly READ_LATENCY+1 cycles after the accept edge, a_rdata=0x155, b_rvalid stays 0.
- A and B both hold wr_req for 4 cycles (addrs 1, 2) -> grants A,B,A,B; data_wea high 4 consecutive cycles.
- A and B issue interleaved reads to pre-written addrs 5 (0x0AA) and 6 (0x3FF) -> one rvalid per cycle, alternating clients, correct data routed to each.
- A writes 0x2AB to addr 7 (old value 0x001) while B reads addr 7 at the same edge -> b_rdata=0x001 without the macro, 0x2AB with BRAM_PORT_ARBITER_FWD_EN.
- Assert rst_n low one cycle after two read accepts -> no rvalid afterwards, data_enb=0 and rstb=1 immediately, first post-reset contention granted to A.
- READ_LATENCY=1 build repeats the first scenario -> rvalid 2 cycles after the accept edge.
